// File: rtl/if_stage_pkg.sv
// Shared pipeline constants used by the instruction-fetch stage.
package if_stage_pkg;
    localparam int unsigned PC_STEP    = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int unsigned INFLIGHT_W = 8;
endpackage

// File: rtl/if_stage_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush has priority over push/pop.
module fetch_queue
    import if_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full queue can still accept a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited requests to imem, in-order responses into a
// small queue toward decode, with redirect flush and stale-response dropping.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned          BUS_WIDTH   = 64,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned          QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect,
    input  logic [BUS_WIDTH-1:0]   redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [BUS_WIDTH-1:0]   imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BUS_WIDTH-1:0]   out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);
    localparam int unsigned QW = BUS_WIDTH + INSTR_WIDTH;
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    logic [BUS_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [BUS_WIDTH-1:0]  resp_pc_q, resp_pc_d;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
    logic [INFLIGHT_W-1:0] drop_q, drop_d;

    logic [QW-1:0]         q_rdata;
    logic [CW-1:0]         q_count;
    logic                  q_empty;
    logic                  fire;
    logic                  keep;
    logic                  discard;
    logic                  do_pop;
    logic [INFLIGHT_W-1:0] live;
    logic [INFLIGHT_W-1:0] used;

    assign out_valid = ~q_empty;
    assign out_pc    = q_rdata[QW-1 -: BUS_WIDTH];
    assign out_instr = q_rdata[INSTR_WIDTH-1:0];
    assign do_pop    = out_valid & out_ready & ~redirect;

    // Only responses that will be kept need a queue slot, and a slot freed by this
    // cycle's pop is usable because a new response cannot land before next cycle.
    assign live = inflight_q - drop_q;
    assign used = live + INFLIGHT_W'(q_count) - INFLIGHT_W'(do_pop);

    assign imem_req_valid = rst_n & ~redirect & (used < INFLIGHT_W'(QUEUE_DEPTH))
                            & (inflight_q != '1);
    assign imem_req_addr  = fetch_pc_q;
    assign fire           = imem_req_valid & imem_req_ready;

    assign discard = imem_resp_valid & (drop_q != '0);
    assign keep    = imem_resp_valid & (drop_q == '0) & ~redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + INFLIGHT_W'(fire) - INFLIGHT_W'(imem_resp_valid);
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = inflight_q - INFLIGHT_W'(imem_resp_valid);
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + BUS_WIDTH'(PC_STEP);
            if (keep) resp_pc_d = resp_pc_q + BUS_WIDTH'(PC_STEP);
            if (discard) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .pop   (do_pop),
        .flush (redirect),
        .wdata ({resp_pc_q, imem_resp_data}),
        .rdata (q_rdata),
        .count (q_count),
        .empty (q_empty)
    );
endmodule
